// File: rtl/led_pkg.sv
// Shared types and constants for the LED fade sequencer.
// Holds the FSM state encoding, the duty limit and the LED mask constants.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } led_state_t;

  localparam logic [7:0] DUTY_MAX   = 8'hFF;
  localparam logic [7:0] MASK_CHASE = 8'h01;
  localparam logic [7:0] MASK_ALL   = 8'hFF;

  // All-LED mask is rotation invariant, so one rotate serves both modes.
  function automatic logic [7:0] rotate_mask(input logic [7:0] m);
    return {m[6:0], m[7]};
  endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Free-running N-bit prescaler that emits a one-clk tick each time the
// counter wraps, giving one tick every 2^N enabled clocks.
module prescaler_tick #(
  parameter int N = 6
) (
  input  logic clk,
  input  logic rstn,
  input  logic ena,
  output logic tick
);

  logic [N-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (ena) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = ena && (cnt == {N{1'b1}});

endmodule

// File: rtl/led_fade_sequencer.sv
// Breathing-LED controller: ramps a shared PWM duty up, holds, ramps down
// and holds, driving either all eight LEDs or a rotating single LED.
module led_fade_sequencer
  import led_pkg::*;
#(
  parameter int PRESC_PWM  = 6,
  parameter int PRESC_STEP = 18,
  parameter int STEP       = 8,
  parameter int HOLD       = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  output logic       busy,
  output logic       cycle_done,
  output logic [7:0] duty,
  output logic [7:0] ledb
);

  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] HOLD8 = 8'(HOLD);

  led_state_t state;
  logic [7:0] mask;
  logic [7:0] hold_cnt;
  logic [7:0] pwm_cnt;
  logic       stop_pending;
  logic       pwm_tick;
  logic       step_tick;
  logic       pwm;
  logic [8:0] duty_up;
  logic [8:0] duty_dn;
  logic [7:0] duty_up_sat;
  logic [7:0] duty_dn_sat;
  logic [7:0] hold_next;

  prescaler_tick #(.N(PRESC_PWM)) u_pwm_presc (
    .clk  (clk),
    .rstn (rstn),
    .ena  (1'b1),
    .tick (pwm_tick)
  );

  prescaler_tick #(.N(PRESC_STEP)) u_step_presc (
    .clk  (clk),
    .rstn (rstn),
    .ena  (1'b1),
    .tick (step_tick)
  );

  // Ninth bit catches overflow on the way up and borrow on the way down.
  assign duty_up     = {1'b0, duty} + STEP9;
  assign duty_dn     = {1'b0, duty} - STEP9;
  assign duty_up_sat = duty_up[8] ? DUTY_MAX : duty_up[7:0];
  assign duty_dn_sat = duty_dn[8] ? 8'h00 : duty_dn[7:0];
  assign hold_next   = hold_cnt + 8'd1;

  assign pwm  = (pwm_cnt < duty);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm_cnt <= 8'h00;
      ledb    <= 8'h00;
    end else begin
      if (pwm_tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      ledb <= mask & {8{pwm}};
    end
  end

  // Sequencer: leaves IDLE on an accepted start, otherwise moves only on step ticks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      duty         <= 8'h00;
      mask         <= 8'h00;
      hold_cnt     <= 8'h00;
      stop_pending <= 1'b0;
      cycle_done   <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (stop && (state != IDLE)) begin
        stop_pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          duty     <= 8'h00;
          mask     <= 8'h00;
          hold_cnt <= 8'h00;
          if (start && !stop) begin
            state        <= UP;
            mask         <= mode ? MASK_CHASE : MASK_ALL;
            stop_pending <= 1'b0;
          end
        end
        UP: begin
          if (step_tick) begin
            duty <= duty_up_sat;
            if (duty_up_sat == DUTY_MAX) begin
              state    <= HOLD_HI;
              hold_cnt <= 8'h00;
            end
          end
        end
        HOLD_HI: begin
          if (step_tick) begin
            hold_cnt <= hold_next;
            if (hold_next == HOLD8) begin
              state <= DOWN;
            end
          end
        end
        DOWN: begin
          if (step_tick) begin
            duty <= duty_dn_sat;
            if (duty_dn_sat == 8'h00) begin
              state    <= HOLD_LO;
              hold_cnt <= 8'h00;
            end
          end
        end
        HOLD_LO: begin
          if (step_tick) begin
            hold_cnt <= hold_next;
            if (hold_next == HOLD8) begin
              cycle_done <= 1'b1;
              hold_cnt   <= 8'h00;
              if (stop_pending || stop) begin
                state        <= IDLE;
                mask         <= 8'h00;
                stop_pending <= 1'b0;
              end else begin
                state <= UP;
                mask  <= rotate_mask(mask);
              end
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Scoreboard bench for led_fade_sequencer: expected duty/cycle events are
// queued by the stimulus and consumed by a monitor on the falling edge.
module tb_led_fade_sequencer;

  typedef struct {
    bit         is_cd;
    logic [7:0] val;
    int         gap;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic       busy;
  logic       cycle_done;
  logic [7:0] duty;
  logic [7:0] ledb;

  logic       rstn_b = 1'b0;
  logic       start_b = 1'b0;
  logic       stop_b = 1'b0;
  logic       mode_b = 1'b0;
  logic       busy_b;
  logic       cycle_done_b;
  logic [7:0] duty_b;
  logic [7:0] ledb_b;

  int checks = 0;
  int errors = 0;
  int cd_count = 0;
  sb_item_t sb[$];

  logic [7:0] prev_duty = 8'h00;
  logic [7:0] acc = 8'h00;
  int gap = 0;
  int bad = 0;

  led_fade_sequencer #(.PRESC_PWM(1), .PRESC_STEP(2), .STEP(64), .HOLD(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .busy       (busy),
    .cycle_done (cycle_done),
    .duty       (duty),
    .ledb       (ledb)
  );

  // Slow-step instance so a single duty value spans whole PWM periods.
  led_fade_sequencer #(.PRESC_PWM(1), .PRESC_STEP(10), .STEP(64), .HOLD(1)) dut_pwm (
    .clk        (clk),
    .rstn       (rstn_b),
    .start      (start_b),
    .stop       (stop_b),
    .mode       (mode_b),
    .busy       (busy_b),
    .cycle_done (cycle_done_b),
    .duty       (duty_b),
    .ledb       (ledb_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic m);
    start = s;
    stop  = p;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic pushCycle(input logic [7:0] m, input bit first);
    sb.push_back('{0, 8'd64,  first ? -1 : 4});
    sb.push_back('{0, 8'd128, 4});
    sb.push_back('{0, 8'd192, 4});
    sb.push_back('{0, 8'd255, 4});
    sb.push_back('{0, 8'd191, 12});
    sb.push_back('{0, 8'd127, 4});
    sb.push_back('{0, 8'd63,  4});
    sb.push_back('{0, 8'd0,   4});
    sb.push_back('{1, m,      8});
  endtask

  task automatic waitCd(input int n);
    for (int i = 0; i < 3000 && cd_count < n; i++) @(negedge clk);
    if (cd_count < n) checkOutput("timeout_cycle_done", cd_count, n);
  endtask

  task automatic waitDuty(input logic [7:0] v);
    for (int i = 0; i < 3000 && duty != v; i++) @(negedge clk);
    if (duty != v) checkOutput("timeout_duty", int'(duty), int'(v));
  endtask

  task automatic measurePwm(input string name, input logic [7:0] target, input int expected);
    int cnt;
    for (int i = 0; i < 12000 && duty_b != target; i++) @(negedge clk);
    if (duty_b != target) checkOutput("timeout_pwm_duty", int'(duty_b), int'(target));
    repeat (4) @(negedge clk);
    cnt = 0;
    repeat (512) begin
      @(negedge clk);
      if (ledb_b[0]) cnt++;
    end
    checkOutput(name, cnt, expected);
  endtask

  // Monitor: every duty change and every cycle_done consumes one queued expectation.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_duty = 8'h00;
      acc = 8'h00;
      gap = 0;
      bad = 0;
    end else begin
      logic [7:0] cur_mask;
      sb_item_t e;
      gap++;
      acc |= ledb;
      cur_mask = 8'h00;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].is_cd) cur_mask = sb[i].val;
      end
      if ((ledb & ~cur_mask) != 8'h00) bad++;
      if (cur_mask == 8'hFF && ledb != 8'h00 && ledb != 8'hFF) bad++;
      if (duty != prev_duty) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_duty_event", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          checkOutput("event_kind_duty", int'(e.is_cd), 0);
          checkOutput("duty_value", int'(duty), int'(e.val));
          if (e.gap >= 0) checkOutput("duty_gap", gap, e.gap);
        end
        gap = 0;
        prev_duty = duty;
      end
      if (cycle_done) begin
        cd_count++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_cycle_done", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          checkOutput("event_kind_cd", int'(e.is_cd), 1);
          checkOutput("cd_mask", int'(acc), int'(e.val));
          checkOutput("cd_gap", gap, e.gap);
        end
        checkOutput("ledb_outside_mask", bad, 0);
        acc = 8'h00;
        bad = 0;
        gap = 0;
      end
    end
  end

  initial begin
    int base;
    fork
      begin
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_cycle_done", cycle_done, 0);
        checkOutput("reset_duty", duty, 0);
        checkOutput("reset_ledb", ledb, 0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Mode 0: two cycles, stop raised during the second ramp-up.
        pushCycle(8'hFF, 1);
        pushCycle(8'hFF, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("busy_after_start", busy, 1);
        waitCd(1);
        waitDuty(8'd64);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("busy_after_stop_req", busy, 1);
        waitCd(2);
        @(negedge clk);
        checkOutput("busy_after_stop", busy, 0);
        checkOutput("duty_after_stop", duty, 0);
        repeat (20) @(negedge clk);
        checkOutput("sb_empty_after_stop", sb.size(), 0);

        // Start and stop together in IDLE: stop wins.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("busy_collision", busy, 0);
        repeat (10) @(negedge clk);
        checkOutput("busy_collision_later", busy, 0);

        // Chase: nine cycles; a start with mode flipped during HOLD_HI is ignored.
        base = cd_count;
        for (int k = 0; k < 9; k++) pushCycle(8'h01 << (k % 8), k == 0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("busy_after_chase_start", busy, 1);
        waitDuty(8'd255);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCd(base + 8);
        waitDuty(8'd64);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCd(base + 9);
        @(negedge clk);
        checkOutput("busy_after_chase", busy, 0);
        repeat (20) @(negedge clk);
        checkOutput("sb_empty_after_chase", sb.size(), 0);

        // Asynchronous reset while ramping down.
        sb.push_back('{0, 8'd64,  -1});
        sb.push_back('{0, 8'd128, 4});
        sb.push_back('{0, 8'd192, 4});
        sb.push_back('{0, 8'd255, 4});
        sb.push_back('{0, 8'd191, 12});
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("sb_empty_before_reset", sb.size(), 0);
        #1 rstn = 1'b0;
        #1;
        checkOutput("midreset_ledb", ledb, 0);
        checkOutput("midreset_duty", duty, 0);
        checkOutput("midreset_busy", busy, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("idle_after_reset_busy", busy, 0);
        checkOutput("idle_after_reset_duty", duty, 0);
      end
      begin
        // PWM duty measurement over 256 PWM ticks (512 clks) at fixed duties.
        repeat (3) @(negedge clk);
        rstn_b = 1'b1;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        checkOutput("pwm_busy_after_start", busy_b, 1);
        measurePwm("pwm_high_clks_duty64", 8'd64, 128);
        measurePwm("pwm_high_clks_duty255", 8'd255, 510);
        measurePwm("pwm_high_clks_duty0", 8'd0, 0);
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
